// File: rtl/lfsr_checker_if.sv
// RNG-bus side of the LFSR checker: per-lane bit beats in, lock/error status out.
// The bench or upstream logic takes the master view, the checker the slave view.
interface lfsr_checker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic             clear;
  logic [WIDTH-1:0] locked;
  logic [WIDTH-1:0] err_flag;
  logic [CNT_W-1:0] err_count;
  logic             all_locked;

  modport master (
    output in_valid, data_in, clear,
    input  locked, err_flag, err_count, all_locked
  );

  modport slave (
    input  in_valid, data_in, clear,
    output locked, err_flag, err_count, all_locked
  );
endinterface

// File: rtl/lfsr_checker.sv
// Per-lane self-seeding Fibonacci LFSR checker with windowed loss-of-lock and a
// shared saturating mismatch counter.
module lfsr_checker #(
  parameter int             WIDTH       = 16,
  parameter int             DEPTH       = 16,
  parameter logic [DEPTH-1:0] TAPS      = DEPTH'(16'h002d),
  parameter int             ERR_WIN     = 64,
  parameter int             LOSS_THRESH = 4,
  parameter int             CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);

  localparam int SC_W  = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(ERR_WIN);
  localparam int EC_W  = $clog2(LOSS_THRESH + 1);
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } lane_state_e;

  // Lane state
  lane_state_e      r_state    [WIDTH];
  logic [DEPTH-1:0] r_hist     [WIDTH];
  logic [SC_W-1:0]  r_seed_cnt [WIDTH];
  logic [WC_W-1:0]  r_win_cnt  [WIDTH];
  logic [EC_W-1:0]  r_win_err  [WIDTH];

  lane_state_e      w_state_nxt    [WIDTH];
  logic [DEPTH-1:0] w_hist_nxt     [WIDTH];
  logic [SC_W-1:0]  w_seed_cnt_nxt [WIDTH];
  logic [WC_W-1:0]  w_win_cnt_nxt  [WIDTH];
  logic [EC_W-1:0]  w_win_err_nxt  [WIDTH];
  logic [WIDTH-1:0] w_pred;
  logic [WIDTH-1:0] w_mis;
  logic [WIDTH-1:0] w_locked;
  logic [WIDTH-1:0] w_locked_nxt;

  // Shared state
  logic [WIDTH-1:0] r_err_flag;
  logic [CNT_W-1:0] r_err_count;
  logic             r_all_locked;

  logic [PC_W-1:0]  w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_count_nxt;

  // Lane next-state logic; w_mis is only ever set for a CHECK lane on a valid beat.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      // NOTE: every w_* gets its hold value first so no path through the case infers a latch.
      w_state_nxt[i]    = r_state[i];
      w_hist_nxt[i]     = r_hist[i];
      w_seed_cnt_nxt[i] = r_seed_cnt[i];
      w_win_cnt_nxt[i]  = r_win_cnt[i];
      w_win_err_nxt[i]  = r_win_err[i];
      w_pred[i]         = 1'b0;
      w_mis[i]          = 1'b0;

      if (bus.in_valid) begin
        unique case (r_state[i])
          SEED: begin
            w_hist_nxt[i] = {bus.data_in[i], r_hist[i][DEPTH-1:1]};
            if (r_seed_cnt[i] == SC_W'(DEPTH - 1)) begin
              w_seed_cnt_nxt[i] = '0;
              // An all-zero register is a dead LFSR state; keep collecting instead.
              if (w_hist_nxt[i] != '0) begin
                w_state_nxt[i]   = CHECK;
                w_win_cnt_nxt[i] = '0;
                w_win_err_nxt[i] = '0;
              end
            end else begin
              w_seed_cnt_nxt[i] = r_seed_cnt[i] + SC_W'(1);
            end
          end

          CHECK: begin
            w_pred[i]     = ^(r_hist[i] & TAPS);
            w_mis[i]      = bus.data_in[i] ^ w_pred[i];
            // The prediction, not the received bit, is fed back so one bad bit costs one error.
            w_hist_nxt[i] = {w_pred[i], r_hist[i][DEPTH-1:1]};
            if ((EC_W + 1)'(r_win_err[i]) + (EC_W + 1)'(w_mis[i]) >= (EC_W + 1)'(LOSS_THRESH)) begin
              w_state_nxt[i]    = SEED;
              w_seed_cnt_nxt[i] = '0;
            end else if (r_win_cnt[i] == WC_W'(ERR_WIN - 1)) begin
              w_win_cnt_nxt[i] = '0;
              w_win_err_nxt[i] = '0;
            end else begin
              w_win_cnt_nxt[i] = r_win_cnt[i] + WC_W'(1);
              w_win_err_nxt[i] = r_win_err[i] + EC_W'(w_mis[i]);
            end
          end

          default: w_state_nxt[i] = SEED;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_locked[i]     = (r_state[i] == CHECK);
      w_locked_nxt[i] = (w_state_nxt[i] == CHECK);
    end
  end

  // Aggregate counter: popcount of this beat's mismatches, saturating add, clear wins.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PC_W'(w_mis[i]);
    end
    w_sum       = SUM_W'(r_err_count) + SUM_W'(w_pop);
    w_count_nxt = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
    if (bus.clear) begin
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i]    <= SEED;
        // NOTE: the history array is reset too, so a fresh seed never inherits stale bits.
        r_hist[i]     <= '0;
        r_seed_cnt[i] <= '0;
        r_win_cnt[i]  <= '0;
        r_win_err[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        // NOTE: non-blocking so every lane register samples the pre-edge values.
        r_state[i]    <= w_state_nxt[i];
        r_hist[i]     <= w_hist_nxt[i];
        r_seed_cnt[i] <= w_seed_cnt_nxt[i];
        r_win_cnt[i]  <= w_win_cnt_nxt[i];
        r_win_err[i]  <= w_win_err_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_flag   <= '0;
      r_err_count  <= '0;
      r_all_locked <= 1'b0;
    end else begin
      r_err_flag   <= w_mis;
      r_err_count  <= w_count_nxt;
      r_all_locked <= &w_locked_nxt;
    end
  end

  assign bus.locked     = w_locked;
  assign bus.err_flag   = r_err_flag;
  assign bus.err_count  = r_err_count;
  assign bus.all_locked = r_all_locked;

endmodule
